// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: converter state encoding, IEEE single layout,
// integer saturation limits.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_UNPACK,
    ST_ALIGN,
    ST_ROUND,
    ST_PACK,
    ST_PUT_Z
  } f2i_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic signed [9:0] FP_BIAS    = 10'sd127;
  localparam logic [31:0]       INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0]       INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0]       UINT32_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/f2i_align.sv
// Barrel shifter placing the 24-bit significand at integer weight for exponent e,
// returning the integer magnitude plus guard/sticky of the discarded fraction.
module f2i_align
  import fpu_pkg::*;
(
  input  logic        [23:0] i_man,
  input  logic signed [9:0]  i_exp,
  output logic        [31:0] o_mag,
  output logic               o_guard,
  output logic               o_sticky
);

  logic [5:0]  w_sh;
  logic [63:0] w_shifted;

  // Shift range 0..32 covers e=-1 too, so the hidden bit lands in the guard slot.
  always_comb begin
    w_sh      = '0;
    w_shifted = '0;
    o_mag     = '0;
    o_guard   = 1'b0;
    o_sticky  = 1'b0;
    if (i_exp < -10'sd1) begin
      o_sticky = |i_man;
    end else if (i_exp <= 10'sd31) begin
      w_sh      = 6'(10'sd31 - i_exp);
      w_shifted = {i_man, 40'd0} >> w_sh;
      o_mag     = w_shifted[63:32];
      o_guard   = w_shifted[31];
      o_sticky  = |w_shifted[30:0];
    end
  end

endmodule

// File: rtl/float_to_int_conv.sv
// Multi-cycle IEEE single to 32-bit integer converter (FCVT.W.S / FCVT.WU.S) with stb/ack
// handshakes. Define F2I_RNE_EN to add input_rm and round-to-nearest-even; default is RTZ.
module float_to_int_conv
  import fpu_pkg::*;
#(
  parameter int unsigned NAN_POS_SAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_a,
  input  logic        input_signed,
`ifdef F2I_RNE_EN
  input  logic [0:0]  input_rm,
`endif
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_nv,
  output logic        output_nx,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [32:0] TWO_POW_31 = 33'h0_8000_0000;

  f2i_state_t         r_state;
  fp32_t              r_a;
  logic               r_signed;
`ifdef F2I_RNE_EN
  logic [0:0]         r_rm;
`endif
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_man;
  logic               r_nan;
  logic               r_inf;
  logic               r_zero;
  logic [31:0]        r_mag;
  logic               r_guard;
  logic               r_sticky;
  logic               r_big;
  logic [32:0]        r_rmag;
  logic [31:0]        r_val;
  logic               r_ack;
  logic               r_z_stb;
  logic [31:0]        r_z;
  logic               r_nv;
  logic               r_nx;

  logic [31:0]        w_mag;
  logic               w_guard;
  logic               w_sticky;
  logic               w_inc;
  logic [32:0]        w_sum;
  logic [31:0]        w_z;
  logic               w_nv;
  logic               w_nx;

  f2i_align u_align (
    .i_man    (r_man),
    .i_exp    (r_exp),
    .o_mag    (w_mag),
    .o_guard  (w_guard),
    .o_sticky (w_sticky)
  );

  always_comb begin
    w_inc = 1'b0;
`ifdef F2I_RNE_EN
    if (r_rm == 1'b1) w_inc = r_guard & (r_sticky | r_mag[0]);
`endif
    w_sum = {1'b0, r_mag} + {32'd0, w_inc};
  end

  // Saturation priority: NaN, then Inf/out-of-range exponent, then post-round range.
  always_comb begin
    w_z  = '0;
    w_nv = 1'b0;
    w_nx = 1'b0;
    if (r_zero) begin
      w_z = '0;
    end else if (r_nan) begin
      w_nv = 1'b1;
      if (r_signed) w_z = (NAN_POS_SAT != 0) ? INT32_MAX : INT32_MIN;
      else          w_z = UINT32_MAX;
    end else if (r_signed) begin
      if (r_inf || r_big || (!r_sign && r_rmag >= TWO_POW_31) ||
          (r_sign && r_rmag > TWO_POW_31)) begin
        w_nv = 1'b1;
        w_z  = r_sign ? INT32_MIN : INT32_MAX;
      end else begin
        w_z  = r_val;
        w_nx = r_guard | r_sticky;
      end
    end else begin
      if (r_sign && (r_inf || r_big || r_rmag != 33'd0)) begin
        w_nv = 1'b1;
        w_z  = '0;
      end else if (r_inf || r_big || r_rmag[32]) begin
        w_nv = 1'b1;
        w_z  = UINT32_MAX;
      end else begin
        w_z  = r_val;
        w_nx = r_guard | r_sticky;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_GET_A;
      r_a      <= '0;
      r_signed <= 1'b0;
`ifdef F2I_RNE_EN
      r_rm     <= '0;
`endif
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_man    <= '0;
      r_nan    <= 1'b0;
      r_inf    <= 1'b0;
      r_zero   <= 1'b0;
      r_mag    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_big    <= 1'b0;
      r_rmag   <= '0;
      r_val    <= '0;
      r_ack    <= 1'b0;
      r_z_stb  <= 1'b0;
      r_z      <= '0;
      r_nv     <= 1'b0;
      r_nx     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_GET_A: begin
          r_ack <= 1'b1;
          if (r_ack && input_a_stb) begin
            r_a      <= fp32_t'(input_a);
            r_signed <= input_signed;
`ifdef F2I_RNE_EN
            r_rm     <= input_rm;
`endif
            r_ack    <= 1'b0;
            r_state  <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          r_sign  <= r_a.sign;
          r_man   <= {r_a.exp != 8'd0, r_a.man};
          r_exp   <= (r_a.exp == 8'd0) ? (10'sd1 - FP_BIAS)
                                       : ($signed({2'b00, r_a.exp}) - FP_BIAS);
          r_nan   <= (r_a.exp == 8'hFF) && (r_a.man != 23'd0);
          r_inf   <= (r_a.exp == 8'hFF) && (r_a.man == 23'd0);
          r_zero  <= (r_a.exp == 8'd0) && (r_a.man == 23'd0);
          r_state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          r_mag    <= w_mag;
          r_guard  <= w_guard;
          r_sticky <= w_sticky;
          r_big    <= r_exp > 10'sd31;
          r_state  <= ST_ROUND;
        end
        ST_ROUND: begin
          r_rmag  <= w_sum;
          r_val   <= r_sign ? (~w_sum[31:0] + 32'd1) : w_sum[31:0];
          r_state <= ST_PACK;
        end
        ST_PACK: begin
          r_z     <= w_z;
          r_nv    <= w_nv;
          r_nx    <= w_nx;
          r_z_stb <= 1'b1;
          r_state <= ST_PUT_Z;
        end
        ST_PUT_Z: begin
          if (output_z_ack) begin
            r_z_stb <= 1'b0;
            r_state <= ST_GET_A;
          end
        end
        default: r_state <= ST_GET_A;
      endcase
    end
  end

  assign input_a_ack  = r_ack;
  assign output_z     = r_z;
  assign output_nv    = r_nv;
  assign output_nx    = r_nx;
  assign output_z_stb = r_z_stb;

endmodule
